// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Brief    : Serialises 10-bit samples as 16-bit MCP4911 write frames, then LDAC.
// Revision : 1.0
// ============================================================================
module dac_spi_tx #(
    parameter int HALF_DIV = 25,
    parameter bit BUF      = 1'b0,
    parameter bit GA_N     = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       load,
    input  logic       ovr_clr,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        CSHI  = 3'd3,
        LDAC  = 3'd4
    } state_t;

    localparam logic [7:0] TICK_AT = 8'(HALF_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic [9:0]  pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic        ld_n_q, ld_n_d;

    logic        tick;
    logic        start;
    logic [9:0]  start_data;
    logic        ovr_set;

    function automatic logic [15:0] frame_word(input logic [9:0] d);
        return {1'b0, BUF, GA_N, 1'b1, d, 2'b00};
    endfunction

    assign tick = (cnt_q == TICK_AT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == IDLE || tick) ? 8'd0 : cnt_q + 8'd1;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        sdi_d      = sdi_q;
        ld_n_d     = ld_n_q;
        start      = 1'b0;
        start_data = data_in;
        ovr_set    = 1'b0;

        // A load mid-frame parks in the pending slot; the LDAC final tick takes it directly.
        if (load && state_q != IDLE && !(state_q == LDAC && tick)) begin
            pend_d   = data_in;
            pend_v_d = 1'b1;
            ovr_set  = pend_v_q;
        end

        case (state_q)
            IDLE: begin
                if (load) start = 1'b1;
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    phase_d = 1'b1;
                    bit_d   = 4'd0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (phase_q) begin
                        sck_d   = 1'b0;
                        phase_d = 1'b0;
                    end else if (bit_q == 4'd15) begin
                        state_d = CSHI;
                        cs_n_d  = 1'b1;
                        sdi_d   = 1'b0;
                    end else begin
                        sck_d   = 1'b1;
                        phase_d = 1'b1;
                        bit_d   = bit_q + 4'd1;
                        shreg_d = shreg_q << 1;
                        sdi_d   = shreg_q[14];
                    end
                end
            end
            CSHI: begin
                // CS is held high for a full SCK period before the latch strobe.
                if (tick) begin
                    if (phase_q) begin
                        state_d = LDAC;
                        ld_n_d  = 1'b0;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
            LDAC: begin
                if (tick) begin
                    ld_n_d   = 1'b1;
                    done_d   = 1'b1;
                    pend_v_d = 1'b0;
                    if (load) begin
                        start   = 1'b1;
                        ovr_set = pend_v_q;
                    end else if (pend_v_q) begin
                        start      = 1'b1;
                        start_data = pend_q;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SETUP;
            busy_d  = 1'b1;
            cs_n_d  = 1'b0;
            shreg_d = frame_word(start_data);
            sdi_d   = shreg_d[15];
        end

        overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            phase_q   <= 1'b0;
            bit_q     <= 4'd0;
            shreg_q   <= 16'd0;
            pend_q    <= 10'd0;
            pend_v_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            ld_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
            ld_n_q    <= ld_n_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = sdi_q;
    assign dac_ld_n = ld_n_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_tx
// Brief    : Self-checking bench for dac_spi_tx (HALF_DIV=25 and HALF_DIV=2 builds).
// Revision : 1.0
// ============================================================================
module tb_dac_spi_tx;

    localparam int H1 = 25;
    localparam int H2 = 2;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b0;
    logic [9:0] data_in = '0;
    logic [9:0] data2   = '0;
    logic       load    = 1'b0;
    logic       load2   = 1'b0;
    logic       ovr_clr = 1'b0;

    logic busy, done, overrun, cs_n, sck, sdi, ld_n;
    logic busy2, done2, overrun2, cs_n2, sck2, sdi2, ld_n2;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    logic [15:0] q1[$];
    logic [15:0] q2[$];

    typedef struct {
        logic [9:0]  data;
        logic [15:0] frame;
    } vec_t;
    vec_t tbl[6];

    dac_spi_tx #(.HALF_DIV(H1), .BUF(1'b0), .GA_N(1'b1)) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load), .ovr_clr(ovr_clr),
        .busy(busy), .done(done), .overrun(overrun), .dac_cs_n(cs_n), .dac_sck(sck),
        .dac_sdi(sdi), .dac_ld_n(ld_n)
    );

    dac_spi_tx #(.HALF_DIV(H2), .BUF(1'b0), .GA_N(1'b1)) dut2 (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data2), .load(load2), .ovr_clr(ovr_clr),
        .busy(busy2), .done(done2), .overrun(overrun2), .dac_cs_n(cs_n2), .dac_sck(sck2),
        .dac_sdi(sdi2), .dac_ld_n(ld_n2)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic frame_chk(input bit which, input logic [15:0] cap, input int nb);
        logic [15:0] exp;
        if ((which ? q2.size() : q1.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame%0d: got unexpected frame 0x%0h, want none", which + 1, cap);
        end else begin
            exp = which ? q2.pop_front() : q1.pop_front();
            chk(which ? "frame2" : "frame1", {16'd0, cap}, {16'd0, exp});
            chk("frame_bits", nb, 16);
        end
    endtask

    // Capture SDI on SCK rising edges while CS is low; a CS fall starts a new frame.
    logic [15:0] cap1 = '0, cap2 = '0;
    int nb1 = 0, nb2 = 0;
    always @(posedge sck or negedge cs_n) begin
        if (!sck) begin cap1 <= '0; nb1 <= 0; end
        else if (!cs_n) begin cap1 <= {cap1[14:0], sdi}; nb1 <= nb1 + 1; end
    end
    always @(posedge sck2 or negedge cs_n2) begin
        if (!sck2) begin cap2 <= '0; nb2 <= 0; end
        else if (!cs_n2) begin cap2 <= {cap2[14:0], sdi2}; nb2 <= nb2 + 1; end
    end
    always @(posedge cs_n)  if (rst_n && mon_en) frame_chk(1'b0, cap1, nb1);
    always @(posedge cs_n2) if (rst_n && mon_en) frame_chk(1'b1, cap2, nb2);

    int cs_run = 0, ld_run = 0, cs_len = 0, ld_len = 0, done_cnt = 0;
    always @(negedge sysclk) begin
        if (!rst_n) begin
            cs_run <= 0;
            ld_run <= 0;
        end else begin
            if (!cs_n) cs_run <= cs_run + 1;
            else if (cs_run != 0) begin cs_len <= cs_run; cs_run <= 0; end
            if (!ld_n) ld_run <= ld_run + 1;
            else if (ld_run != 0) begin ld_len <= ld_run; ld_run <= 0; end
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulse_load(input bit which, input logic [9:0] d);
        if (which) begin data2 = d; load2 = 1'b1; end
        else begin data_in = d; load = 1'b1; end
        @(negedge sysclk);
        load  = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int limit, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge sysclk);
            n++;
            if (which ? busy2 : busy) nbusy++;
        end while (!(which ? done2 : done) && n < limit);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, want end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nb, d0;
        tbl[0] = '{10'h200, 16'h3800};
        tbl[1] = '{10'h3FF, 16'h3FFC};
        tbl[2] = '{10'h000, 16'h3000};
        tbl[3] = '{10'h155, 16'h3554};
        tbl[4] = '{10'h2AA, 16'h3AA8};
        tbl[5] = '{10'h001, 16'h3004};

        // {busy, done, overrun, cs_n, sck, sdi, ld_n}
        cycles(3);
        chk("reset1", {25'd0, busy, done, overrun, cs_n, sck, sdi, ld_n}, 32'b0001001);
        chk("reset2", {25'd0, busy2, done2, overrun2, cs_n2, sck2, sdi2, ld_n2}, 32'b0001001);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycles(3);

        // Single frames from the table
        for (int i = 0; i < 6; i++) begin
            q1.push_back(tbl[i].frame);
            pulse_load(1'b0, tbl[i].data);
            chk("busy_after_load", busy, 1'b1);
            wait_done(1'b0, 2000, n, nb);
            chk("frame_len", n + 1, 36 * H1 + 1);
            chk("busy_cycles", nb + 1, 36 * H1);
            chk("busy_at_done", busy, 1'b0);
            cycles(2);
            chk("cs_low_len", cs_len, 33 * H1);
            chk("ld_low_len", ld_len, H1);
            chk("frames_left", q1.size(), 0);
        end
        chk("overrun_idle", overrun, 1'b0);

        // One pending sample: sent back-to-back, CS falls with done
        q1.push_back(16'h3FFC);
        q1.push_back(16'h3004);
        pulse_load(1'b0, 10'h3FF);
        cycles(299);
        pulse_load(1'b0, 10'h001);
        wait_done(1'b0, 2000, n, nb);
        chk("b2b_first_done", n + 301, 36 * H1 + 1);
        chk("b2b_cs_at_done", cs_n, 1'b0);
        chk("b2b_busy_at_done", busy, 1'b1);
        wait_done(1'b0, 2000, n, nb);
        chk("b2b_second_len", n, 36 * H1);
        chk("b2b_overrun", overrun, 1'b0);
        cycles(2);
        chk("b2b_frames_left", q1.size(), 0);

        // Overwritten pending sample: A then C, overrun sticky; set beats clear
        q1.push_back(16'h3A00);
        q1.push_back(16'h3C00);
        pulse_load(1'b0, 10'h280);
        cycles(99);
        pulse_load(1'b0, 10'h111);
        chk("ovr_after_B", overrun, 1'b0);
        cycles(98);
        ovr_clr = 1'b1;
        pulse_load(1'b0, 10'h300);
        ovr_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1'b1);
        wait_done(1'b0, 2000, n, nb);
        wait_done(1'b0, 2000, n, nb);
        cycles(2);
        chk("ovr_sticky", overrun, 1'b1);
        chk("ovr_frames_left", q1.size(), 0);
        ovr_clr = 1'b1;
        cycles(1);
        ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Load on the LDAC final tick with an empty pending slot
        q1.push_back(16'h3248);
        q1.push_back(16'h3DB4);
        pulse_load(1'b0, 10'h092);
        cycles(899);
        pulse_load(1'b0, 10'h36D);
        chk("ldac_load_done", done, 1'b1);
        chk("ldac_load_busy", busy, 1'b1);
        chk("ldac_load_cs", cs_n, 1'b0);
        wait_done(1'b0, 2000, n, nb);
        chk("ldac_load_len", n, 36 * H1);
        chk("ldac_load_busy_cnt", nb, 36 * H1 - 1);
        chk("ldac_load_ovr", overrun, 1'b0);
        cycles(2);

        // Asynchronous reset mid-SHIFT aborts the frame
        d0 = done_cnt;
        pulse_load(1'b0, 10'h3C3);
        cycles(399);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {25'd0, busy, done, overrun, cs_n, sck, sdi, ld_n}, 32'b0001001);
        cycles(3);
        rst_n = 1'b1;
        cycles(1000);
        chk("no_done_on_abort", done_cnt, d0);
        chk("abort_frames_left", q1.size(), 0);
        q1.push_back(16'h3AA8);
        pulse_load(1'b0, 10'h2AA);
        wait_done(1'b0, 2000, n, nb);
        chk("post_reset_len", n + 1, 36 * H1 + 1);
        cycles(2);
        chk("post_reset_done_cnt", done_cnt, d0 + 1);
        chk("post_reset_frames_left", q1.size(), 0);

        // HALF_DIV=2 build
        q2.push_back(16'h3554);
        pulse_load(1'b1, 10'h155);
        wait_done(1'b1, 500, n, nb);
        chk("hd2_frame_len", n + 1, 36 * H2 + 1);
        cycles(2);
        chk("hd2_frames_left", q2.size(), 0);
        chk("hd2_overrun", overrun2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
